// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory end of the core load/store port. It accepts one
//               request at a time, waits WAIT_CYCLES, then performs the
//               byte/half/word access and returns the extended load data.
//               Optional macro MISALIGN_TRAP_EN flags misaligned or
//               unsupported accesses on RSP_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_F3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam int         c_OW        = c_AW + 2;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [c_OW-1:0]   off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              w_accept;
    logic [c_OW-1:0]   w_req_off;
    logic [c_AW-1:0]   w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_val;
    logic [31:0]       w_load_data;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_be;
    logic              w_err;
    logic              w_in_resp;
    logic              w_unused;

    // Only the low offset bits select RAM; the rest of the address wraps.
    assign w_req_off = REQ_ADDR[c_OW-1:0] - ADDR_BASE[c_OW-1:0];
    assign w_unused  = ^REQ_ADDR[31:c_OW];

    assign w_accept  = REQ_VALID && (state_q == S_IDLE);
    assign w_idx     = off_q[c_OW-1:2];
    assign w_lane    = off_q[1:0];
    assign w_word    = mem[w_idx];
    assign w_byte    = w_word[8*w_lane +: 8];
    assign w_half    = off_q[1] ? w_word[31:16] : w_word[15:0];
    assign w_in_resp = (state_q == S_RESP) && RESET;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = c_WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_val = 32'd0;
        case (f3_q)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_val = {16'd0, w_half};
            3'b010:  w_load_val = w_word;
            default: w_load_val = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = wdata_q;
        case (f3_q)
            3'b000: begin
                w_be      = 4'b0001 << w_lane;
                w_wr_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                w_be      = off_q[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{wdata_q[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_err = 1'b0;
        case (f3_q)
            3'b000:         w_err = 1'b0;
            3'b001:         w_err = off_q[0];
            3'b010:         w_err = (off_q[1:0] != 2'b00);
            3'b100:         w_err = we_q;
            3'b101:         w_err = we_q || off_q[0];
            default:        w_err = 1'b1;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    assign w_load_data = (we_q || w_err) ? 32'd0 : w_load_val;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= REQ_WE;
                f3_q    <= REQ_F3;
                off_q   <= w_req_off;
                wdata_q <= REQ_WDATA;
            end
            if (state_q == S_RESP) begin
                rdata_q <= w_load_data;
            end
        end
    end

    // RAM is never cleared; a reset in the response cycle suppresses the write.
    always_ff @(posedge CLK) begin
        if (w_in_resp && we_q && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign REQ_READY = (state_q == S_IDLE);
    assign RSP_VALID = w_in_resp;
    assign RSP_ERR   = w_in_resp && w_err;
    assign RSP_RDATA = w_in_resp ? w_load_data : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (WAIT_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        CLK;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [2:0]  REQ_F3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;

    int n_checks;
    int n_pass;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2),
        .ADDR_BASE   (32'h0000_0000)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_F3    (REQ_F3),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issue one request, then sample at falling edges until the response.
    // lat counts cycles after the accept edge (0 = timed out).
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_low);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_F3    = f3;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        lat     = 0;
        rdy_low = 1'b1;
        rd      = 32'hxxxx_xxxx;
        er      = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            if (REQ_READY) rdy_low = 1'b0;
            if (RSP_VALID) begin
                lat = i;
                rd  = RSP_RDATA;
                er  = RSP_ERR;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic load_check(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp);
        logic [31:0] rd;
        logic        er, rl;
        int          lat;
        access(1'b0, f3, addr, 32'd0, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || rd !== exp || er !== 1'b0)
            $display("FAIL %s: rdata=%h err=%b lat=%0d, required rdata=%h err=0 lat=3",
                     name, rd, er, lat, exp);
        else n_pass++;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        er, rl;
        int          lat;
        access(1'b1, f3, addr, wd, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || rd !== 32'd0 || er !== 1'b0)
            $display("FAIL store@%h: rdata=%h err=%b lat=%0d, required rdata=0 err=0 lat=3",
                     addr, rd, er, lat);
        else n_pass++;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_ERR !== 1'b0)
            $display("FAIL reset_hold: ready=%b valid=%b err=%b, required 1 0 0",
                     REQ_READY, RSP_VALID, RSP_ERR);
        else n_pass++;
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0 || RSP_ERR !== 1'b0)
            $display("FAIL reset_idle: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR);
        else n_pass++;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] rd;
        logic        er, rl;
        int          lat;
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || rl !== 1'b1 || rd !== 32'd0)
            $display("FAIL sw_latency: lat=%0d ready_low=%b rdata=%h, required 3 1 0", lat, rl, rd);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1)
            $display("FAIL sw_one_cycle: valid=%b ready=%b, required 0 1", RSP_VALID, REQ_READY);
        else n_pass++;
        access(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || rl !== 1'b1 || rd !== 32'hDEADBEEF)
            $display("FAIL lw_round_trip: lat=%0d ready_low=%b rdata=%h, required 3 1 deadbeef",
                     lat, rl, rd);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'hDEADBEEF)
            $display("FAIL rdata_hold: valid=%b rdata=%h, required 0 deadbeef", RSP_VALID, RSP_RDATA);
        else n_pass++;
    endtask

    task automatic test_extension();
        store(3'b010, 32'h20, 32'h80FF7F01);
        load_check("lb_0x23",  3'b000, 32'h23, 32'hFFFFFF80);
        load_check("lbu_0x23", 3'b100, 32'h23, 32'h00000080);
        load_check("lh_0x20",  3'b001, 32'h20, 32'h00007F01);
        load_check("lhu_0x22", 3'b101, 32'h22, 32'h000080FF);
        load_check("lb_0x21",  3'b000, 32'h21, 32'h0000007F);
        load_check("lbu_0x20", 3'b100, 32'h20, 32'h00000001);
        load_check("lh_0x22",  3'b001, 32'h22, 32'hFFFF80FF);
    endtask

    task automatic test_partial_store();
        store(3'b010, 32'h30, 32'h11223344);
        store(3'b000, 32'h31, 32'h000000AA);
        store(3'b001, 32'h32, 32'h0000BEEF);
        load_check("partial_lw", 3'b010, 32'h30, 32'hBEEFAA44);
        store(3'b011, 32'h30, 32'hFFFFFFFF);
        load_check("bad_f3_store", 3'b010, 32'h30, 32'hBEEFAA44);
    endtask

    task automatic test_wrap();
        store(3'b010, 32'h1000, 32'h12345678);
        load_check("wrap_lw", 3'b010, 32'h0000, 32'h12345678);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_F3    = 3'b010;
        REQ_ADDR  = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (RSP_VALID) pulses++;
        end
        REQ_VALID = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (RSP_VALID) pulses++;
        end
        n_checks++;
        if (pulses !== 1)
            $display("FAIL held_valid: responses=%0d, required 1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        pulses = 0;
        store(3'b010, 32'h40, 32'hCAFEF00D);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b1;
        REQ_F3    = 3'b010;
        REQ_ADDR  = 32'h40;
        REQ_WDATA = 32'h5;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        RESET     = 1'b0;
        if (RSP_VALID) pulses++;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (RSP_VALID) pulses++;
            @(negedge CLK);
        end
        n_checks++;
        if (pulses !== 0 || REQ_READY !== 1'b1)
            $display("FAIL reset_mid_op: responses=%0d ready=%b, required 0 1", pulses, REQ_READY);
        else n_pass++;
        load_check("reset_discard", 3'b010, 32'h40, 32'hCAFEF00D);
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er, rl;
        int          lat;
`ifdef MISALIGN_TRAP_EN
        access(1'b1, 3'b010, 32'h41, 32'h99887766, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL misalign_sw: lat=%0d err=%b rdata=%h, required 3 1 0", lat, er, rd);
        else n_pass++;
        load_check("misalign_unchanged", 3'b010, 32'h40, 32'hCAFEF00D);
        access(1'b0, 3'b001, 32'h21, 32'd0, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL misalign_lh: lat=%0d err=%b rdata=%h, required 3 1 0", lat, er, rd);
        else n_pass++;
`else
        access(1'b1, 3'b010, 32'h41, 32'h99887766, rd, er, lat, rl);
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0)
            $display("FAIL misalign_sw: lat=%0d err=%b rdata=%h, required 3 0 0", lat, er, rd);
        else n_pass++;
        load_check("misalign_written", 3'b010, 32'h40, 32'h99887766);
        load_check("misalign_lh",      3'b001, 32'h21, 32'h00007F01);
        load_check("misalign_lw",      3'b010, 32'h23, 32'h80FF7F01);
        load_check("bad_f3_load",      3'b011, 32'h20, 32'h00000000);
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        RESET     = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_F3    = 3'd0;
        REQ_ADDR  = 32'd0;
        REQ_WDATA = 32'd0;
        test_reset();
        test_word_round_trip();
        test_extension();
        test_partial_store();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
